// File: rtl/pipe_pkg.sv
// pipe_pkg: shared width, word type and drain-state encoding for the pipe drain stage
package pipe_pkg;
  localparam int PIPE_WIDTH = 28;
  typedef logic [PIPE_WIDTH-1:0] pipe_word_t;
  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} drain_state_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one WIDTH-bit storage entry with load enable, plus a stored parity bit
// when PIPE_DRAIN_STAGE_PARITY_EN is defined.
// Ports: clk, rst_n (async active-low), load, d -> q; optional par_d -> par_q.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
  ,
  input  logic             par_d,
  output logic             par_q
`endif
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= d;
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else if (load) par_q <= par_d;
`endif
endmodule

// File: rtl/pipe_drain_stage.sv
// pipe_drain_stage: 2-entry skid buffer handing latch-bank words downstream over valid/ready.
// Ports: clk, rst_n (async active-low), in_valid/in_data/in_ready (upstream),
// out_valid/out_data/out_ready (downstream), flush (sync discard), count (words held).
// Optional macro PIPE_DRAIN_STAGE_PARITY_EN adds par_inject input and par_err output.
module pipe_drain_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
  ,
  input  logic             par_inject,
  output logic             par_err
`endif
);
  drain_state_t     state, state_nx;
  logic             accepted, drained, main_load, skid_load;
  logic [WIDTH-1:0] skid_q, main_d;
  assign accepted = in_valid & in_ready;
  assign drained  = out_valid & out_ready;
  assign count    = state;
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (accepted ? FULL1 : EMPTY) :
               state == FULL1 ? (accepted & !drained ? FULL2 : !accepted & drained ? EMPTY : FULL1) :
               (drained ? FULL1 : FULL2);
  end
  // Main loads a fresh word when empty or when draining in FULL1; in FULL2 it refills from skid.
  assign main_load = !flush & (state == FULL2 ? drained : accepted & (state == EMPTY | drained));
  assign skid_load = !flush & state == FULL1 & accepted & !drained;
  assign main_d    = state == FULL2 ? skid_q : in_data;
  // Outputs are registered from the next state so in_ready never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      out_valid <= state_nx != EMPTY;
      in_ready  <= state_nx != FULL2;
    end
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
  logic in_par, skid_par, main_par;
  assign in_par  = ^in_data ^ par_inject;
  assign par_err = out_valid & ((^out_data) != main_par);
  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .d(main_d), .q(out_data),
    .par_d(state == FULL2 ? skid_par : in_par), .par_q(main_par));
  pipe_slot #(.WIDTH(WIDTH)) u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .d(in_data), .q(skid_q),
    .par_d(in_par), .par_q(skid_par));
`else
  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .d(main_d), .q(out_data));
  pipe_slot #(.WIDTH(WIDTH)) u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .d(in_data), .q(skid_q));
`endif
  always_ff @(posedge clk)
    if (rst_n) begin
      assert (count != 2'd3) else $error("count overflow");
      assert (!(drained && count == 2'd0)) else $error("count underflow");
    end
endmodule

// File: tb/tb_pipe_drain_stage.sv
// tb_pipe_drain_stage: vector table, corner sequences and randomized traffic against a queue model
module tb_pipe_drain_stage;
  import pipe_pkg::*;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, out_ready = 0, flush = 0, par_inject = 0;
  pipe_word_t in_data = '0;
  logic       in_ready, out_valid;
  pipe_word_t out_data;
  logic [1:0] count;
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
  logic par_err;
`endif
  int checks = 0, failures = 0;
  pipe_word_t q[$];
  bit qi[$];
  always #5 clk = ~clk;
  pipe_drain_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush), .count(count)
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
    , .par_inject(par_inject), .par_err(par_err)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // Checks current outputs against the queue model, then applies one clock edge.
  task automatic tick(input logic iv, input pipe_word_t d, input logic ordy, input logic fl, input logic inj);
    bit rdy;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; par_inject = inj;
    #1;
    chk("m_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("m_count", {30'b0, count}, q.size());
    chk("m_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    if (q.size() > 0) chk("m_data", {4'b0, out_data}, {4'b0, q[0]});
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
    chk("m_par_err", {31'b0, par_err}, {31'b0, q.size() > 0 && qi[0]});
`endif
    rdy = q.size() < 2;
    if (fl) begin
      q.delete(); qi.delete();
    end else begin
      if (q.size() > 0 && ordy) begin void'(q.pop_front()); void'(qi.pop_front()); end
      if (iv && rdy) begin q.push_back(d); qi.push_back(inj); end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  typedef struct {
    logic iv; pipe_word_t d; logic ordy; logic fl;
    logic ev; pipe_word_t ed; logic [1:0] ec; logic er;
  } vec_t;
  vec_t vt[10];
  initial begin
    vt[0] = '{1, 28'hABCDEF1, 0, 0, 1, 28'hABCDEF1, 1, 1};
    vt[1] = '{1, 28'h1234567, 0, 0, 1, 28'hABCDEF1, 2, 0};
    vt[2] = '{1, 28'h7654321, 0, 0, 1, 28'hABCDEF1, 2, 0};
    vt[3] = '{0, 28'h0,       1, 0, 1, 28'h1234567, 1, 1};
    vt[4] = '{0, 28'h0,       1, 0, 0, 28'h0,       0, 1};
    vt[5] = '{1, 28'h5555555, 1, 0, 1, 28'h5555555, 1, 1};
    vt[6] = '{1, 28'hAAAAAAA, 1, 0, 1, 28'hAAAAAAA, 1, 1};
    vt[7] = '{1, 28'h0000001, 0, 0, 1, 28'hAAAAAAA, 2, 0};
    vt[8] = '{1, 28'hFFFFFFF, 0, 1, 0, 28'h0,       0, 1};
    vt[9] = '{0, 28'h0,       1, 0, 0, 28'h0,       0, 1};
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_count", {30'b0, count}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_data", {4'b0, out_data}, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl, 0);
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ev});
      chk($sformatf("vec%0d_count", i), {30'b0, count}, {30'b0, vt[i].ec});
      chk($sformatf("vec%0d_ready", i), {31'b0, in_ready}, {31'b0, vt[i].er});
      if (vt[i].ev) chk($sformatf("vec%0d_data", i), {4'b0, out_data}, {4'b0, vt[i].ed});
    end
    tick(1, 28'h0000AAA, 0, 0, 0);
    tick(1, 28'h0000BBB, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_count", {30'b0, count}, 0);
    chk("arst_ready", {31'b0, in_ready}, 1);
    q.delete(); qi.delete();
    @(negedge clk) rst_n = 1;
    tick(1, 28'h0000001, 1, 0, 0);
    chk("arst_first", {4'b0, out_data}, 1);
    chk("arst_first_valid", {31'b0, out_valid}, 1);
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick(1, 28'(i), 1, 0, 0);
      chk("stream_count", {30'b0, count}, 1);
      chk("stream_data", {4'b0, out_data}, i);
    end
    tick(0, 0, 1, 0, 0);
`ifdef PIPE_DRAIN_STAGE_PARITY_EN
    tick(1, 28'h0000003, 1, 0, 1);
    chk("par_inject_err", {31'b0, par_err}, 1);
    tick(1, 28'h0000005, 1, 0, 0);
    chk("par_clean_err", {31'b0, par_err}, 0);
    tick(0, 0, 1, 0, 0);
`endif
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 28'($urandom), 1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
